// File: rtl/ledpanel_pkg.sv
// Shared definitions for the LED panel write path: memory geometry, write masks, FSM states.
package ledpanel_pkg;

    function automatic int unsigned mem_size(input int unsigned chained);
        return chained * 4096;
    endfunction

    function automatic int unsigned addr_width(input int unsigned chained);
        return 12 + $clog2(chained);
    endfunction

    localparam logic [3:0] WR_R   = 4'b0100;
    localparam logic [3:0] WR_G   = 4'b0010;
    localparam logic [3:0] WR_B   = 4'b0001;
    localparam logic [3:0] WR_RGB = 4'b0111;

    typedef enum logic [0:0] {
        StIdle,
        StFill
    } fb_state_e;

    typedef struct packed {
        logic [3:0]  wr;
        logic [15:0] addr;
        logic [23:0] wdat;
    } fb_write_t;

endpackage

// File: rtl/fb_write_arbiter_if.sv
// Bundle of requester, fill-control and ledpanel write-port signals around fb_write_arbiter.
interface fb_write_arbiter_if;

    logic        a_valid;
    logic        a_ready;
    logic [15:0] a_addr;
    logic [3:0]  a_wr;
    logic [23:0] a_wdat;

    logic        b_valid;
    logic        b_ready;
    logic [15:0] b_addr;
    logic [3:0]  b_wr;
    logic [23:0] b_wdat;

    logic        fill_start;
    logic [23:0] fill_color;
    logic        fill_busy;
    logic        fill_done;

    logic        ctrl_en;
    logic [3:0]  ctrl_wr;
    logic [15:0] ctrl_addr;
    logic [23:0] ctrl_wdat;

    // Requesters and fill controller side.
    modport master (
        output a_valid, a_addr, a_wr, a_wdat,
        output b_valid, b_addr, b_wr, b_wdat,
        output fill_start, fill_color,
        input  a_ready, b_ready, fill_busy, fill_done,
        input  ctrl_en, ctrl_wr, ctrl_addr, ctrl_wdat
    );

    // Arbiter side.
    modport slave (
        input  a_valid, a_addr, a_wr, a_wdat,
        input  b_valid, b_addr, b_wr, b_wdat,
        input  fill_start, fill_color,
        output a_ready, b_ready, fill_busy, fill_done,
        output ctrl_en, ctrl_wr, ctrl_addr, ctrl_wdat
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the last-served pointer moves only when advance_i confirms a grant.
module rr_arbiter2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o
);

    logic last_b_q, last_b_d;

    always_comb begin
        gnt_o = 2'b00;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_b_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

    always_comb begin
        last_b_d = last_b_q;
        if (advance_i && (gnt_o != 2'b00)) begin
            last_b_d = gnt_o[1];
        end
    end

    // Reset as if B was served last so A wins the first contention.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_b_q <= 1'b1;
        end else begin
            last_b_q <= last_b_d;
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// Merges two pixel-write requesters onto the ledpanel write port and runs whole-framebuffer fills.
module fb_write_arbiter
    import ledpanel_pkg::*;
#(
    parameter int unsigned CHAINED = 2
) (
    input logic              ctrl_clk,
    input logic              rst_n,
    fb_write_arbiter_if.slave bus
);

    localparam int unsigned MEM_SIZE   = mem_size(CHAINED);
    localparam int unsigned ADDR_WIDTH = addr_width(CHAINED);
    // One spare bit so the terminal compare never sees a wrapped count.
    localparam int unsigned CNT_WIDTH  = ADDR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(MEM_SIZE - 1);

    fb_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [23:0]          color_q, color_d;
    logic                 ctrl_en_q, ctrl_en_d;
    fb_write_t            out_q, out_d;
    logic                 fill_done_q, fill_done_d;

    fb_write_t  a_req, b_req;
    logic [1:0] req, gnt;
    logic       advance;
    logic       a_ready_c, b_ready_c;

    assign a_req = '{wr: bus.a_wr, addr: bus.a_addr, wdat: bus.a_wdat};
    assign b_req = '{wr: bus.b_wr, addr: bus.b_addr, wdat: bus.b_wdat};
    assign req   = {bus.b_valid, bus.a_valid};

    rr_arbiter2 u_rr_arbiter2 (
        .clk_i    (ctrl_clk),
        .rst_ni   (rst_n),
        .req_i    (req),
        .advance_i(advance),
        .gnt_o    (gnt)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        color_d     = color_q;
        ctrl_en_d   = 1'b0;
        out_d       = out_q;
        fill_done_d = 1'b0;
        a_ready_c   = 1'b0;
        b_ready_c   = 1'b0;
        advance     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.fill_start) begin
                    color_d = bus.fill_color;
                    state_d = StFill;
                end else begin
                    a_ready_c = gnt[0];
                    b_ready_c = gnt[1];
                    advance   = gnt[0] | gnt[1];
                    ctrl_en_d = gnt[0] | gnt[1];
                    if (gnt[0]) begin
                        out_d = a_req;
                    end else if (gnt[1]) begin
                        out_d = b_req;
                    end
                end
            end
            StFill: begin
                ctrl_en_d = 1'b1;
                out_d     = '{wr: WR_RGB, addr: 16'(cnt_q), wdat: color_q};
                if (cnt_q == CNT_LAST) begin
                    fill_done_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = StIdle;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge ctrl_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            color_q     <= '0;
            ctrl_en_q   <= 1'b0;
            out_q       <= '0;
            fill_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            color_q     <= color_d;
            ctrl_en_q   <= ctrl_en_d;
            out_q       <= out_d;
            fill_done_q <= fill_done_d;
        end
    end

    // Readies are combinational, so hold them low while reset is asserted.
    assign bus.a_ready   = a_ready_c & rst_n;
    assign bus.b_ready   = b_ready_c & rst_n;
    assign bus.fill_busy = (state_q == StFill);
    assign bus.fill_done = fill_done_q;
    assign bus.ctrl_en   = ctrl_en_q;
    assign bus.ctrl_wr   = out_q.wr;
    assign bus.ctrl_addr = out_q.addr;
    assign bus.ctrl_wdat = out_q.wdat;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Scoreboard bench for fb_write_arbiter: stimulus pushes expected writes, a monitor pops on ctrl_en.
module tb_fb_write_arbiter;

    localparam int unsigned NFILL = 8192;

    typedef struct packed {
        logic [15:0] addr;
        logic [3:0]  wr;
        logic [23:0] wdat;
        logic        done;
    } exp_t;

    logic ctrl_clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   done_cnt;
    exp_t sb[$];

    fb_write_arbiter_if bus ();

    fb_write_arbiter #(
        .CHAINED(2)
    ) dut (
        .ctrl_clk(ctrl_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    initial ctrl_clk = 1'b0;
    always #5 ctrl_clk = ~ctrl_clk;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: every ctrl_en cycle must match the oldest expected write.
    initial begin
        exp_t e;
        exp_t act;
        forever begin
            @(negedge ctrl_clk);
            if (bus.ctrl_en === 1'b1) begin
                act = '{addr: bus.ctrl_addr, wr: bus.ctrl_wr, wdat: bus.ctrl_wdat,
                        done: bus.fill_done};
                if (bus.fill_done === 1'b1) done_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got %0h expected none", act);
                end else begin
                    e = sb.pop_front();
                    check("ctrl_write", 64'(act), 64'(e));
                end
            end else begin
                check("stray_done", 64'(bus.fill_done), 64'(1'b0));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] all_outs();
        return 64'({bus.a_ready, bus.b_ready, bus.fill_busy, bus.fill_done, bus.ctrl_en,
                    bus.ctrl_wr, bus.ctrl_addr, bus.ctrl_wdat});
    endfunction

    task automatic clear_inputs();
        bus.a_valid = 0; bus.a_addr = 0; bus.a_wr = 0; bus.a_wdat = 0;
        bus.b_valid = 0; bus.b_addr = 0; bus.b_wr = 0; bus.b_wdat = 0;
        bus.fill_start = 0; bus.fill_color = 0;
    endtask

    task automatic send(input bit use_b, input logic [15:0] addr, input logic [3:0] wr,
                        input logic [23:0] wdat);
        @(posedge ctrl_clk); #1;
        if (use_b) begin
            bus.b_valid = 1; bus.b_addr = addr; bus.b_wr = wr; bus.b_wdat = wdat;
        end else begin
            bus.a_valid = 1; bus.a_addr = addr; bus.a_wr = wr; bus.a_wdat = wdat;
        end
        @(negedge ctrl_clk);
        check(use_b ? "b_ready" : "a_ready", 64'({bus.a_ready, bus.b_ready}),
              use_b ? 64'(2'b01) : 64'(2'b10));
        sb.push_back('{addr: addr, wr: wr, wdat: wdat, done: 1'b0});
        @(posedge ctrl_clk); #1;
        bus.a_valid = 0;
        bus.b_valid = 0;
    endtask

    task automatic push_fill(input logic [23:0] color);
        for (int i = 0; i < int'(NFILL); i++) begin
            sb.push_back('{addr: 16'(i), wr: 4'h7, wdat: color, done: (i == int'(NFILL) - 1)});
        end
    endtask

    initial begin
        int busy_cnt;
        int n;
        int done_before;
        bit hit;
        checks   = 0;
        errors   = 0;
        done_cnt = 0;
        rst_n    = 1'b0;
        clear_inputs();

        // Reset with inputs toggling: everything stays 0.
        repeat (4) begin
            @(posedge ctrl_clk); #1;
            bus.a_valid = 1'($urandom); bus.b_valid = 1'($urandom);
            bus.a_addr = 16'($urandom); bus.b_addr = 16'($urandom);
            bus.a_wr = 4'($urandom); bus.b_wr = 4'($urandom);
            bus.a_wdat = 24'($urandom); bus.b_wdat = 24'($urandom);
            bus.fill_start = 1'($urandom); bus.fill_color = 24'($urandom);
            @(negedge ctrl_clk);
            check("reset_outputs", all_outs(), 64'd0);
        end
        @(posedge ctrl_clk); #1;
        clear_inputs();
        @(negedge ctrl_clk);
        rst_n = 1'b1;

        // First request after reset, then a B write with an empty mask.
        send(1'b0, 16'h0010, 4'h4, 24'h3F0000);
        send(1'b1, 16'h0020, 4'h0, 24'h00FF00);

        // Contention: grants alternate starting with A.
        @(posedge ctrl_clk); #1;
        bus.a_valid = 1; bus.a_addr = 16'h0100; bus.a_wr = 4'h7; bus.a_wdat = 24'h111111;
        bus.b_valid = 1; bus.b_addr = 16'h0200; bus.b_wr = 4'h1; bus.b_wdat = 24'h000022;
        for (int i = 0; i < 6; i++) begin
            @(negedge ctrl_clk);
            check("contend_grant", 64'({bus.a_ready, bus.b_ready}),
                  (i % 2 == 0) ? 64'(2'b10) : 64'(2'b01));
            if (i % 2 == 0) sb.push_back('{16'h0100, 4'h7, 24'h111111, 1'b0});
            else            sb.push_back('{16'h0200, 4'h1, 24'h000022, 1'b0});
            @(posedge ctrl_clk); #1;
        end
        bus.a_valid = 0;
        bus.b_valid = 0;
        repeat (2) @(negedge ctrl_clk);
        check("idle_hold", 64'({bus.ctrl_en, bus.ctrl_addr, bus.ctrl_wr, bus.ctrl_wdat}),
              64'({1'b0, 16'h0200, 4'h1, 24'h000022}));
        check("contend_drained", 64'(sb.size()), 64'd0);

        // Plain fill.
        done_before = done_cnt;
        @(posedge ctrl_clk); #1;
        bus.fill_start = 1; bus.fill_color = 24'h010203;
        push_fill(24'h010203);
        @(posedge ctrl_clk); #1;
        bus.fill_start = 0; bus.fill_color = 24'h0;
        busy_cnt = 0;
        for (int c = 0; c < 8300; c++) begin
            @(negedge ctrl_clk);
            if (bus.fill_busy === 1'b1) busy_cnt++;
        end
        check("fill_busy_cycles", 64'(busy_cnt), 64'(NFILL));
        check("fill_done_count", 64'(done_cnt - done_before), 64'd1);
        check("fill_drained", 64'(sb.size()), 64'd0);

        // Fill and A request in the same cycle: fill wins, A follows with no bubble.
        done_before = done_cnt;
        @(posedge ctrl_clk); #1;
        bus.fill_start = 1; bus.fill_color = 24'h0A0B0C;
        bus.a_valid = 1; bus.a_addr = 16'h0123; bus.a_wr = 4'h2; bus.a_wdat = 24'h00AB00;
        push_fill(24'h0A0B0C);
        sb.push_back('{16'h0123, 4'h2, 24'h00AB00, 1'b0});
        n = 0;
        for (int c = 0; c < 9000; c++) begin
            @(negedge ctrl_clk);
            if (bus.a_ready === 1'b1) break;
            n++;
            @(posedge ctrl_clk); #1;
            bus.fill_start = 0;
        end
        check("collide_ready_low", 64'(n), 64'(NFILL + 1));
        check("collide_done_at_grant", 64'(bus.fill_done), 64'd1);
        @(posedge ctrl_clk); #1;
        bus.a_valid = 0;
        repeat (3) @(negedge ctrl_clk);
        check("collide_drained", 64'(sb.size()), 64'd0);
        check("collide_done_count", 64'(done_cnt - done_before), 64'd1);

        // Second fill_start at count 100 is ignored.
        done_before = done_cnt;
        @(posedge ctrl_clk); #1;
        bus.fill_start = 1; bus.fill_color = 24'h112233;
        push_fill(24'h112233);
        @(posedge ctrl_clk); #1;
        bus.fill_start = 0;
        repeat (100) @(posedge ctrl_clk);
        #1;
        bus.fill_start = 1; bus.fill_color = 24'hFFFFFF;
        @(posedge ctrl_clk); #1;
        bus.fill_start = 0;
        repeat (8200) @(negedge ctrl_clk);
        check("restart_drained", 64'(sb.size()), 64'd0);
        check("restart_done_count", 64'(done_cnt - done_before), 64'd1);
        check("restart_idle", 64'(bus.fill_busy), 64'd0);

        // Reset mid-fill aborts immediately.
        done_before = done_cnt;
        @(posedge ctrl_clk); #1;
        bus.fill_start = 1; bus.fill_color = 24'h445566;
        push_fill(24'h445566);
        @(posedge ctrl_clk); #1;
        bus.fill_start = 0;
        hit = 0;
        for (int c = 0; c < 1000 && !hit; c++) begin
            @(negedge ctrl_clk);
            if (bus.ctrl_en === 1'b1 && bus.ctrl_addr == 16'd500) hit = 1;
        end
        check("midfill_reached", 64'(hit), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("midfill_reset_outputs", all_outs(), 64'd0);
        check("midfill_written", 64'(NFILL - sb.size()), 64'd501);
        @(posedge ctrl_clk);
        @(negedge ctrl_clk);
        check("midfill_held_outputs", all_outs(), 64'd0);
        rst_n = 1'b1;
        sb.delete();
        send(1'b1, 16'h0777, 4'h5, 24'hC0FFEE);
        repeat (20) @(negedge ctrl_clk);
        check("midfill_no_done", 64'(done_cnt - done_before), 64'd0);
        check("final_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
